// File: rtl/pblaze_axil_port_bridge.sv
// AXI4-Lite slave exposing four 32-bit registers that a PicoBlaze core can
// also reach through its port bus: bytes of reg0..reg3 are readable on
// port_id 0x00..0x0F, and reg3 bytes are writable on port_id 0x10..0x13.
// An AXI write to reg0 raises irq; the core acknowledges it by reading port 0x00.

module pblaze_axil_port_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [7:0]                      port_id,
  input  logic [7:0]                      out_port,
  input  logic                            write_strobe,
  output logic [7:0]                      in_port,
  input  logic                            read_strobe,
  output logic                            irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;

  logic [DW-1:0] regs     [4];
  logic [DW-1:0] reg_next [4];

  logic          aw_ready_q;
  logic          b_valid_q;
  logic          ar_ready_q;
  logic          r_valid_q;
  logic [DW-1:0] r_data_q;
  logic [7:0]    in_port_q;
  logic          irq_q;

  logic          write_fire;
  logic          read_fire;
  logic [1:0]    wr_idx;
  logic [1:0]    rd_idx;
  logic          core_wr_hit;
  logic          core_rd_hit;
  logic          irq_ack;
  logic          unused_addr_bits;

  // Byte offsets inside a word carry no meaning; only the word index is used.
  assign wr_idx           = S_AXI_AWADDR[3:2];
  assign rd_idx           = S_AXI_ARADDR[3:2];
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // AW and W are only ever accepted together, so one ready flag serves both.
  assign write_fire  = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign read_fire   = ar_ready_q & S_AXI_ARVALID;
  assign core_wr_hit = write_strobe & (port_id[7:2] == 6'b000100);
  assign core_rd_hit = (port_id[7:4] == 4'h0);
  assign irq_ack     = read_strobe & (port_id == 8'h00);

  // Next register contents: AXI byte lanes first, then the core byte on top.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      reg_next[i] = regs[i];
      if (write_fire && (wr_idx == 2'(i))) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (S_AXI_WSTRB[b]) begin
            reg_next[i][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          end
        end
      end
    end
    if (core_wr_hit) begin
      reg_next[3][{port_id[1:0], 3'b000} +: 8] = out_port;
    end
  end

  // Register file update.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= reg_next[i];
      end
    end
  end

  // Write channel: single-cycle ready pulse, then hold BVALID until taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      aw_ready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_q & ~aw_ready_q;
      if (write_fire) begin
        b_valid_q <= 1'b1;
      end else if (b_valid_q && S_AXI_BREADY) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Read channel: capture the addressed word at the handshake, hold until taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      ar_ready_q <= S_AXI_ARVALID & ~r_valid_q & ~ar_ready_q;
      if (read_fire) begin
        r_valid_q <= 1'b1;
        r_data_q  <= regs[rd_idx];
      end else if (r_valid_q && S_AXI_RREADY) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // Core read port: one byte of the register file, zero outside the window.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      in_port_q <= 8'h00;
    end else if (core_rd_hit) begin
      in_port_q <= regs[port_id[3:2]][{port_id[1:0], 3'b000} +: 8];
    end else begin
      in_port_q <= 8'h00;
    end
  end

  // Interrupt: raised by an AXI write to reg0, which beats a same-cycle ack.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_q <= 1'b0;
    end else if (write_fire && (wr_idx == 2'd0)) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = 2'b00;
  assign in_port       = in_port_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_pblaze_axil_port_bridge.sv
// Self-checking bench for pblaze_axil_port_bridge: directed scenarios with
// literal expectations, then randomized AXI and core traffic checked every
// cycle against a register-file model kept in the bench.

module tb_pblaze_axil_port_bridge;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  port_id;
  logic [7:0]  out_port;
  logic        write_strobe;
  logic [7:0]  in_port;
  logic        read_strobe;
  logic        irq;

  int n_cmp;
  int n_fail;
  bit rand_done;

  pblaze_axil_port_bridge #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .in_port       (in_port),
    .read_strobe   (read_strobe),
    .irq           (irq)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain register array plus the outstanding-response flags.
  logic [31:0] m_reg [4];
  logic [31:0] m_rdata;
  logic [7:0]  m_in_port;
  logic        m_irq;
  logic        m_bvalid;
  logic        m_rvalid;

  // Word i after this edge: AXI bytes selected by the strobes, core byte wins.
  function automatic logic [31:0] model_next(input int i);
    logic [31:0] v;
    int          wi;
    v  = m_reg[i];
    wi = int'(awaddr) / 4;
    if (awvalid && wvalid && awready && (wi == i)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (write_strobe && (i == 3) && (port_id >= 8'h10) && (port_id <= 8'h13)) begin
      v[8*(int'(port_id) - 16) +: 8] = out_port;
    end
    return v;
  endfunction

  function automatic logic [7:0] model_core_byte();
    logic [31:0] w;
    if (port_id < 8'h10) begin
      w = m_reg[int'(port_id) / 4];
      return w[8*(int'(port_id) % 4) +: 8];
    end
    return 8'h00;
  endfunction

  // Advance the model on every clock edge; reset clears everything at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] <= 32'h0;
      m_rdata   <= 32'h0;
      m_in_port <= 8'h00;
      m_irq     <= 1'b0;
      m_bvalid  <= 1'b0;
      m_rvalid  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) m_reg[i] <= model_next(i);
      m_in_port <= model_core_byte();
      if (arvalid && arready) begin
        m_rdata  <= m_reg[int'(araddr) / 4];
        m_rvalid <= 1'b1;
      end else if (m_rvalid && rready) begin
        m_rvalid <= 1'b0;
      end
      if (awvalid && wvalid && awready) begin
        m_bvalid <= 1'b1;
      end else if (m_bvalid && bready) begin
        m_bvalid <= 1'b0;
      end
      if (awvalid && wvalid && awready && (awaddr < 4'h4)) m_irq <= 1'b1;
      else if (read_strobe && (port_id == 8'h00))          m_irq <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model, on the falling edge.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      checkOutput("in_port", {24'h0, in_port}, {24'h0, m_in_port});
      checkOutput("irq", {31'h0, irq}, {31'h0, m_irq});
      checkOutput("bvalid", {31'h0, bvalid}, {31'h0, m_bvalid});
      checkOutput("rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
      checkOutput("wready_eq_awready", {31'h0, wready}, {31'h0, awready});
      checkOutput("aw_accept_while_bvalid", {31'h0, awready & m_bvalid}, 32'h0);
      if (m_rvalid) begin
        checkOutput("rdata", rdata, m_rdata);
        checkOutput("rresp", {30'h0, rresp}, 32'h0);
      end
      if (m_bvalid) checkOutput("bresp", {30'h0, bresp}, 32'h0);
    end
  endtask

  // Drive AW+W together until accepted; returns the wait in cycles.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat);
    int n;
    n       = 0;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    forever begin
      @(negedge clk);
      if (awready) break;
      n++;
      if (n > 200) begin
        checkOutput("aw_handshake_timeout", {31'h0, awready}, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat     = n;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    n       = 0;
    araddr  = a;
    arvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (arready) break;
      n++;
      if (n > 200) begin
        checkOutput("ar_handshake_timeout", {31'h0, arready}, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (rvalid && rready) break;
      n++;
      if (n > 200) begin
        checkOutput("r_handshake_timeout", {31'h0, rvalid}, 32'h1);
        break;
      end
    end
    d = rdata;
    @(posedge clk);
    #1;
  endtask

  // Random core-bus activity plus random B/R back-pressure, one cycle per call.
  task automatic applyStimulus();
    int sel;
    @(posedge clk);
    #1;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       port_id = 8'h00;
      1:       port_id = 8'($urandom_range(0, 15));
      2:       port_id = 8'($urandom_range(16, 19));
      default: port_id = 8'($urandom);
    endcase
    out_port     = 8'($urandom);
    write_strobe = ($urandom_range(0, 3) == 0);
    read_strobe  = ($urandom_range(0, 3) == 0);
    bready       = ($urandom_range(0, 3) != 0);
    rready       = ($urandom_range(0, 3) != 0);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rand_done    = 1'b0;
    rst_n        = 1'b0;
    awaddr       = 4'h0;
    awvalid      = 1'b0;
    wdata        = 32'h0;
    wstrb        = 4'h0;
    wvalid       = 1'b0;
    bready       = 1'b1;
    araddr       = 4'h0;
    arvalid      = 1'b0;
    rready       = 1'b1;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;

    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_ready", {30'h0, awready, arready}, 32'h0);
    rst_n = 1'b1;

    // First write straight after reset release: accepted on the second edge.
    axi_write(4'h0, 32'h1, 4'hF, lat);
    checkOutput("first_write_latency", lat, 32'd1);
    axi_write(4'h4, 32'h2, 4'hF, lat);
    axi_write(4'h8, 32'h3, 4'hF, lat);
    axi_write(4'hC, 32'h4, 4'hF, lat);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd);
      checkOutput("readback_word", rd, 32'(i + 1));
    end

    // Partial strobes, then an unaligned read of the same word.
    axi_write(4'h4, 32'h0, 4'hF, lat);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, lat);
    axi_read(4'h4, rd);
    checkOutput("wstrb_0101", rd, 32'h00BB00DD);
    axi_read(4'h6, rd);
    checkOutput("unaligned_read", rd, 32'h00BB00DD);

    // Interrupt raise by reg0 write and clear by core read of port 0x00.
    axi_write(4'h0, 32'h11223344, 4'hF, lat);
    checkOutput("irq_set", {31'h0, irq}, 32'h1);
    port_id     = 8'h00;
    read_strobe = 1'b1;
    @(posedge clk);
    #1;
    read_strobe = 1'b0;
    @(negedge clk);
    checkOutput("irq_clear", {31'h0, irq}, 32'h0);
    checkOutput("in_port_reg0", {24'h0, in_port}, 32'h44);
    port_id = 8'h09;
    @(posedge clk);
    #1;
    checkOutput("in_port_reg2_b1", {24'h0, in_port}, 32'h00);
    port_id = 8'h20;
    @(posedge clk);
    #1;
    checkOutput("in_port_outside", {24'h0, in_port}, 32'h00);

    // Core byte write colliding with a full AXI write to reg3.
    fork
      axi_write(4'hC, 32'hFFFFFFFF, 4'hF, lat);
      begin
        for (int n = 0; n < 200; n++) begin
          @(negedge clk);
          if (awready) break;
        end
        port_id      = 8'h12;
        out_port     = 8'h5A;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
      end
    join
    axi_read(4'hC, rd);
    checkOutput("core_wins_reg3", rd, 32'hFF5AFFFF);

    // A held write response blocks the next write until BREADY.
    bready = 1'b0;
    axi_write(4'h8, 32'h55, 4'hF, lat);
    awaddr  = 4'h4;
    wdata   = 32'h66;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("held_bvalid", {31'h0, bvalid}, 32'h1);
      checkOutput("blocked_awready", {31'h0, awready}, 32'h0);
    end
    @(posedge clk);
    #1;
    bready = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (awready) break;
      if (n == 200) checkOutput("second_write_timeout", {31'h0, awready}, 32'h1);
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    axi_read(4'h4, rd);
    checkOutput("second_write_data", rd, 32'h66);

    // Reset while a response is pending: everything clears immediately.
    bready = 1'b0;
    axi_write(4'h0, 32'h99, 4'hF, lat);
    @(negedge clk);
    checkOutput("pending_bvalid", {31'h0, bvalid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_bvalid", {31'h0, bvalid}, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("no_resp_after_reset", {31'h0, bvalid}, 32'h0);
    end
    @(posedge clk);
    #1;
    bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd);
      checkOutput("reg_after_reset", rd, 32'h0);
    end

    // Randomized AXI traffic alongside random core activity.
    fork
      begin
        for (int it = 0; it < 200; it++) begin
          int          op;
          logic [31:0] d;
          op = int'($urandom_range(0, 2));
          if (op == 0) begin
            axi_write(4'($urandom), $urandom, 4'($urandom), lat);
          end else if (op == 1) begin
            axi_read(4'($urandom), d);
          end else begin
            fork
              axi_write(4'($urandom), $urandom, 4'($urandom), lat);
              axi_read(4'($urandom), d);
            join
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) applyStimulus();
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        bready       = 1'b1;
        rready       = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pblaze_axil_port_bridge.md
PBLAZE_AXIL_PORT_BRIDGE -- requirements
Module: pblaze_axil_port_bridge

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI byte address width; bits [3:2] select reg0..reg3.
REQ-003 ACLK  in  1  single clock; all logic rising-edge.
REQ-004 ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 S_AXI_AWADDR  in  4  write address.
REQ-006 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write-address handshake.
REQ-007 S_AXI_WDATA  in  32  write data.
REQ-008 S_AXI_WSTRB  in  4  byte enables.
REQ-009 S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write-data handshake.
REQ-010 S_AXI_BRESP  out  2  always 2'b00 (OKAY).
REQ-011 S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write-response handshake.
REQ-012 S_AXI_ARADDR  in  4  read address.
REQ-013 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read-address handshake.
REQ-014 S_AXI_RDATA  out  32  read data.
REQ-015 S_AXI_RRESP  out  2  always 2'b00.
REQ-016 S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read-data handshake.
REQ-017 port_id  in  8  PicoBlaze port address.
REQ-018 out_port / write_strobe  in / in  8 / 1  core write data and strobe.
REQ-019 in_port / read_strobe  out / in  8 / 1  core read data and strobe.
REQ-020 irq  out  1  interrupt to core.

Function
REQ-021 SHALL hold four 32-bit registers reg0..reg3, each AXI read/write with per-byte WSTRB.
REQ-022 Write: AWREADY and WREADY SHALL pulse together for one cycle when AWVALID & WVALID & !BVALID & !(AWREADY); register updated in that cycle; BVALID asserted next cycle, held until BREADY; no new write accepted while BVALID=1.
REQ-023 AW without W (or W without AW) SHALL not be accepted; it waits until both are valid.
REQ-024 Read: ARREADY SHALL pulse one cycle when ARVALID & !RVALID & !ARREADY; RDATA registered from reg[ARADDR[3:2]] in that cycle; RVALID next cycle, held (RDATA stable) until RREADY.
REQ-025 Read and write in the same cycle SHALL proceed independently; read of a register being written returns the pre-write value.
REQ-026 Core read: in_port SHALL be registered, one cycle after port_id: port_id 0x00..0x0F -> byte port_id[1:0] of reg[port_id[3:2]]; any other port_id -> 0x00.
REQ-027 Core write: write_strobe with port_id 0x10..0x13 SHALL write out_port into byte port_id[1:0] of reg3; other port_ids ignored.
REQ-028 Simultaneous core write and AXI write to the same reg3 byte: core write SHALL win; other bytes take AXI data.
REQ-029 irq SHALL set the cycle after an accepted AXI write to reg0 (any strobe) and clear the cycle after read_strobe with port_id 0x00; if both occur in one cycle, set wins.
REQ-030 Unaligned AXI address bits [1:0] SHALL be ignored.

Reset
REQ-031 ARESETN low SHALL immediately force reg0..reg3=0, in_port=0, irq=0, AWREADY=WREADY=BVALID=ARREADY=RVALID=0, RDATA=0.
REQ-032 Reset mid-transaction SHALL abandon the transaction; no response issued after release.
REQ-033 First accepted transaction SHALL be possible on the second rising edge after ARESETN deasserts.

Verification
REQ-034 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> 0x00000001..0x00000004, BRESP=RRESP=0.
REQ-035 Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 after reg1=0 -> read 0x00BB00DD.
REQ-036 AXI write reg0 -> irq=1 next cycle; core read_strobe port_id 0x00 -> in_port=reg0[7:0], irq=0 next cycle.
REQ-037 Core write_strobe port_id 0x12 out_port 0x5A, same cycle AXI write 0xFFFFFFFF to 0xC -> read reg3 = 0xFF5AFFFF.
REQ-038 Hold BREADY=0 for 10 cycles -> BVALID stays 1, AWREADY stays 0 for a second pending write; accepted after BREADY.
REQ-039 Assert ARESETN=0 while BVALID=1 -> BVALID and all registers 0 immediately; no response after release.
